ysyx_22041207_rd_arbiter_n: RTL and testbench
=============================================

Name: ysyx_22041207_rd_arbiter_n

Overview:
- N-master read-channel arbiter for the core's simple read interface: address phase valid/ready, data phase data_valid/data_ready.
- Successor to the fixed 2-input (MEM over IF) read selector.
- Generalised to NUM_MASTERS requesters, with selectable fixed-priority or round-robin arbitration and an explicit 3-state FSM.
- Grant is released only on a completed data handshake.
- Sits between the IF/MEM/DMA-style read clients and the single AXI read bridge.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (>=2); master 0 is highest priority in fixed mode.
- RW_DATA_WIDTH, 64, read data width.
- RW_ADDR_WIDTH, 64, read address width.
- SIZE_WIDTH, 8, transfer size field width.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- GNT_W, $clog2(NUM_MASTERS), grant index width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- m_r_valid_i  in  NUM_MASTERS  per-master address request valid.
- m_r_ready_o  out  NUM_MASTERS  per-master address accepted.
- m_r_addr_i  in  NUM_MASTERS*RW_ADDR_WIDTH  packed addresses; master k occupies slice k.
- m_r_size_i  in  NUM_MASTERS*SIZE_WIDTH  packed sizes.
- m_r_data_valid_o  out  NUM_MASTERS  per-master read data valid.
- m_r_data_ready_i  in  NUM_MASTERS  per-master read data accepted.
- m_data_read_o  out  RW_DATA_WIDTH  shared read data bus; qualify with m_r_data_valid_o.
- s_r_valid_o  out  1  request valid to bridge.
- s_r_ready_i  in  1  bridge accepted address.
- s_r_addr_o  out  RW_ADDR_WIDTH  forwarded address.
- s_r_size_o  out  SIZE_WIDTH  forwarded size.
- s_r_data_valid_i  in  1  bridge data valid.
- s_r_data_ready_o  out  1  data accepted.
- s_data_read_i  in  RW_DATA_WIDTH  bridge read data.
- gnt_idx_o  out  GNT_W  current grant index.
- busy_o  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, any time including mid-transaction):
  - state = IDLE, gnt_idx = 0, rr_ptr = 0.
  - All outputs 0.
  - An in-flight transaction is abandoned; the bridge sees s_r_valid_o drop immediately.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any m_r_valid_i is set, register the winner into gnt_idx and go to ADDR.
  - Arbitration latency is 1 cycle: request in cycle t, s_r_valid_o in cycle t+1.
- ADDR:
  - s_r_valid_o = m_r_valid_i[gnt]; s_r_addr_o and s_r_size_o = slice[gnt].
  - m_r_ready_o[gnt] = s_r_ready_i; all other bits 0.
  - On s_r_valid_o && s_r_ready_i, go to DATA.
  - If the granted master drops valid before the handshake, return to IDLE with no rr_ptr update (abort).
- DATA:
  - m_r_data_valid_o[gnt] = s_r_data_valid_i; s_r_data_ready_o = m_r_data_ready_i[gnt].
  - On s_r_data_valid_i && s_r_data_ready_o:
    - go to IDLE;
    - in round-robin mode, rr_ptr <= gnt+1, wrapping to 0 at NUM_MASTERS-1.
  - Data held by the bridge while ready is low is not consumed; the state holds.
- Non-granted masters always see ready=0 and data_valid=0.
- m_data_read_o = s_data_read_i while in DATA, else 0.
- Outside ADDR, s_r_valid_o, s_r_addr_o and s_r_size_o are 0.
- Fixed mode: lowest set index wins.
- Round-robin mode: first set index at or after rr_ptr, searching modulo NUM_MASTERS.
- Simultaneous completion and new requests: the FSM returns to IDLE and re-arbitrates the next cycle, giving one bubble cycle per transaction.
- Requests arriving during ADDR/DATA are held off (ready=0) and are never dropped.
- A single outstanding transaction at a time; no reordering.

Decomposition:
- Package ysyx_22041207_rd_arb_pkg holds:
  - the state enum (IDLE/ADDR/DATA);
  - ARB_FIXED=0 and ARB_RR=1 constants;
  - slice-index helper functions for the packed buses.
- Sub-module ysyx_22041207_rr_picker: combinational (req vector, base pointer, mode) -> (found, index), using a double-width rotate-and-priority-encode. It is instantiated once.

Test Plan:
- Single request: NUM_MASTERS=2, master 1 requests addr 0x8000_0000 size 8.
  - Cycle t+1: s_r_valid_o=1, s_r_addr_o=0x8000_0000, gnt_idx_o=1.
  - Bridge returns 0xDEAD_BEEF: m_r_data_valid_o=2'b10, m_data_read_o=0xDEAD_BEEF.
- Fixed priority: masters 0 and 1 request in the same cycle, ARB_MODE=0 → master 0 granted first, master 1 granted only after master 0's data handshake plus one IDLE cycle.
- Round-robin: NUM_MASTERS=4, ARB_MODE=1, all four request continuously → grant order 0,1,2,3,0; each transaction takes ADDR+DATA+1 IDLE cycle.
- Back-pressure: s_r_ready_i low for 5 cycles, then m_r_data_ready_i[gnt] low for 3 cycles after data_valid → FSM holds in ADDR, then DATA; addr/size stable; no grant change; exactly one data beat delivered.
- Abort and reset:
  - Granted master drops valid in ADDR → return to IDLE, rr_ptr unchanged.
  - rst asserted mid-DATA → all outputs 0 in the same cycle, busy_o=0, the next request is granted normally.

Source files
------------

// File: rtl/ysyx_22041207_rd_arb_pkg.sv
// Shared types and helpers for the N-master read-channel arbiter.
package ysyx_22041207_rd_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } rd_state_e;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Low bit position of slice idx in a packed bus of width-wide fields.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/ysyx_22041207_rr_picker.sv
// Combinational request picker: lowest set request at or after base (mode=1),
// or lowest set request overall (mode=0).
module ysyx_22041207_rr_picker #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned GNT_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [GNT_W-1:0]       base,
  input  logic                   mode,
  output logic                   found,
  output logic [GNT_W-1:0]       idx
);

  logic [2*NUM_MASTERS-1:0] dbl;
  logic [NUM_MASTERS-1:0]   rot;
  int unsigned              shift;
  int unsigned              pos;

  // Rotate the doubled request vector down by base, priority-encode, then
  // add base back (mod NUM_MASTERS) to recover the absolute index.
  always_comb begin
    shift = mode ? 32'(base) : 32'd0;
    dbl   = {req, req} >> shift;
    rot   = dbl[NUM_MASTERS-1:0];
    found = |rot;
    pos   = 0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (rot[k]) pos = shift + unsigned'(k);
    end
    if (pos >= NUM_MASTERS) pos = pos - NUM_MASTERS;
    idx = GNT_W'(pos);
  end

endmodule

// File: rtl/ysyx_22041207_rd_arbiter_n.sv
// N-master read-channel arbiter: one outstanding transaction, grant held from
// address phase until the data handshake completes.
module ysyx_22041207_rd_arbiter_n
  import ysyx_22041207_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS   = 2,
  parameter int unsigned RW_DATA_WIDTH = 64,
  parameter int unsigned RW_ADDR_WIDTH = 64,
  parameter int unsigned SIZE_WIDTH    = 8,
  parameter int unsigned ARB_MODE      = ARB_FIXED,
  localparam int unsigned GNT_W        = $clog2(NUM_MASTERS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_MASTERS-1:0]               m_r_valid_i,
  output logic [NUM_MASTERS-1:0]               m_r_ready_o,
  input  logic [NUM_MASTERS*RW_ADDR_WIDTH-1:0] m_r_addr_i,
  input  logic [NUM_MASTERS*SIZE_WIDTH-1:0]    m_r_size_i,
  output logic [NUM_MASTERS-1:0]               m_r_data_valid_o,
  input  logic [NUM_MASTERS-1:0]               m_r_data_ready_i,
  output logic [RW_DATA_WIDTH-1:0]             m_data_read_o,
  output logic                                 s_r_valid_o,
  input  logic                                 s_r_ready_i,
  output logic [RW_ADDR_WIDTH-1:0]             s_r_addr_o,
  output logic [SIZE_WIDTH-1:0]                s_r_size_o,
  input  logic                                 s_r_data_valid_i,
  output logic                                 s_r_data_ready_o,
  input  logic [RW_DATA_WIDTH-1:0]             s_data_read_i,
  output logic [GNT_W-1:0]                     gnt_idx_o,
  output logic                                 busy_o
);

  rd_state_e          state_q, state_d;
  logic [GNT_W-1:0]   gnt_q, gnt_d;
  logic [GNT_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               pick_found;
  logic [GNT_W-1:0]   pick_idx;

  logic [RW_ADDR_WIDTH-1:0] addr_arr [NUM_MASTERS];
  logic [SIZE_WIDTH-1:0]    size_arr [NUM_MASTERS];

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_slice
    assign addr_arr[k] = m_r_addr_i[slice_lo(k, RW_ADDR_WIDTH) +: RW_ADDR_WIDTH];
    assign size_arr[k] = m_r_size_i[slice_lo(k, SIZE_WIDTH) +: SIZE_WIDTH];
  end

  ysyx_22041207_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .GNT_W       (GNT_W)
  ) u_picker (
    .req   (m_r_valid_i),
    .base  (rr_ptr_q),
    .mode  (ARB_MODE == ARB_RR),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state and outputs; everything is steered by the registered grant.
  always_comb begin
    state_d          = state_q;
    gnt_d            = gnt_q;
    rr_ptr_d         = rr_ptr_q;
    m_r_ready_o      = '0;
    m_r_data_valid_o = '0;
    m_data_read_o    = '0;
    s_r_valid_o      = 1'b0;
    s_r_addr_o       = '0;
    s_r_size_o       = '0;
    s_r_data_ready_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          state_d = StAddr;
        end
      end
      StAddr: begin
        s_r_valid_o        = m_r_valid_i[gnt_q];
        s_r_addr_o         = addr_arr[gnt_q];
        s_r_size_o         = size_arr[gnt_q];
        m_r_ready_o[gnt_q] = s_r_ready_i;
        // A withdrawn request aborts without advancing the round-robin pointer.
        if (!m_r_valid_i[gnt_q]) state_d = StIdle;
        else if (s_r_ready_i)    state_d = StData;
      end
      StData: begin
        m_r_data_valid_o[gnt_q] = s_r_data_valid_i;
        s_r_data_ready_o        = m_r_data_ready_i[gnt_q];
        m_data_read_o           = s_data_read_i;
        if (s_r_data_valid_i && m_r_data_ready_i[gnt_q]) begin
          state_d = StIdle;
          if (ARB_MODE == ARB_RR) begin
            rr_ptr_d = (gnt_q == GNT_W'(NUM_MASTERS - 1)) ? '0 : gnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign gnt_idx_o = gnt_q;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_ysyx_22041207_rd_arbiter_n.sv
// Bench for the read arbiter: a 2-master fixed-priority instance and a
// 4-master round-robin instance, each checked every cycle against a
// transaction-level model, plus directed literal checks.
module tb_ysyx_22041207_rd_arbiter_n;

  typedef struct packed {
    logic [3:0]       valid;
    logic [3:0]       dready;
    logic [3:0][63:0] addr;
    logic [3:0][7:0]  size;
    logic             s_ready;
    logic             s_dvalid;
    logic [63:0]      s_data;
  } in_t;

  typedef struct packed {
    logic [3:0]  m_ready;
    logic [3:0]  m_dvalid;
    logic [63:0] m_data;
    logic        s_valid;
    logic [63:0] s_addr;
    logic [7:0]  s_size;
    logic        s_dready;
    logic [31:0] gnt;
    logic        busy;
  } exp_t;

  // owner = granted master, phase 0 none / 1 address / 2 data, ptr = RR start
  typedef struct packed {
    int phase;
    int owner;
    int ptr;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  in_t  fi, ri;

  logic [1:0]  f_ready, f_dvalid;
  logic [63:0] f_data, f_saddr;
  logic        f_svalid, f_sdready, f_busy;
  logic [7:0]  f_ssize;
  logic [0:0]  f_gnt;

  logic [3:0]  r_ready, r_dvalid;
  logic [63:0] r_data, r_saddr;
  logic        r_svalid, r_sdready, r_busy;
  logic [7:0]  r_ssize;
  logic [1:0]  r_gnt;

  int n_chk  = 0;
  int n_fail = 0;
  int beats  = 0;

  always #5 clk = ~clk;

  ysyx_22041207_rd_arbiter_n #(
    .NUM_MASTERS (2),
    .ARB_MODE    (0)
  ) dut_fix (
    .clk              (clk),
    .rst              (rst),
    .m_r_valid_i      (fi.valid[1:0]),
    .m_r_ready_o      (f_ready),
    .m_r_addr_i       (fi.addr[1:0]),
    .m_r_size_i       (fi.size[1:0]),
    .m_r_data_valid_o (f_dvalid),
    .m_r_data_ready_i (fi.dready[1:0]),
    .m_data_read_o    (f_data),
    .s_r_valid_o      (f_svalid),
    .s_r_ready_i      (fi.s_ready),
    .s_r_addr_o       (f_saddr),
    .s_r_size_o       (f_ssize),
    .s_r_data_valid_i (fi.s_dvalid),
    .s_r_data_ready_o (f_sdready),
    .s_data_read_i    (fi.s_data),
    .gnt_idx_o        (f_gnt),
    .busy_o           (f_busy)
  );

  ysyx_22041207_rd_arbiter_n #(
    .NUM_MASTERS (4),
    .ARB_MODE    (1)
  ) dut_rr (
    .clk              (clk),
    .rst              (rst),
    .m_r_valid_i      (ri.valid),
    .m_r_ready_o      (r_ready),
    .m_r_addr_i       (ri.addr),
    .m_r_size_i       (ri.size),
    .m_r_data_valid_o (r_dvalid),
    .m_r_data_ready_i (ri.dready),
    .m_data_read_o    (r_data),
    .s_r_valid_o      (r_svalid),
    .s_r_ready_i      (ri.s_ready),
    .s_r_addr_o       (r_saddr),
    .s_r_size_o       (r_ssize),
    .s_r_data_valid_i (ri.s_dvalid),
    .s_r_data_ready_o (r_sdready),
    .s_data_read_i    (ri.s_data),
    .gnt_idx_o        (r_gnt),
    .busy_o           (r_busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Expected outputs for the current cycle and the model state after the edge.
  function automatic void mdl_eval(input int n, input bit rr, input in_t x, input mdl_t m,
                                   output exp_t e, output mdl_t nm);
    int g;
    bit found;
    e     = '0;
    nm    = m;
    g     = m.owner;
    e.gnt  = 32'(m.owner);
    e.busy = (m.phase != 0);
    found = 1'b0;
    if (m.phase == 0) begin
      for (int j = 0; j < n; j++) begin
        int k;
        k = ((rr ? m.ptr : 0) + j) % n;
        if (!found && x.valid[k]) begin
          found    = 1'b1;
          nm.owner = k;
          nm.phase = 1;
        end
      end
    end else if (m.phase == 1) begin
      e.s_valid    = x.valid[g];
      e.s_addr     = x.addr[g];
      e.s_size     = x.size[g];
      e.m_ready[g] = x.s_ready;
      if (!x.valid[g]) nm.phase = 0;
      else if (x.s_ready) nm.phase = 2;
    end else begin
      e.m_dvalid[g] = x.s_dvalid;
      e.s_dready    = x.dready[g];
      e.m_data      = x.s_data;
      if (x.s_dvalid && x.dready[g]) begin
        nm.phase = 0;
        if (rr) nm.ptr = (g + 1) % n;
      end
    end
  endfunction

  // Per-cycle comparison of both instances against the model.
  initial begin
    mdl_t mf, mr, nf, nr;
    exp_t ef, er;
    mf = '0;
    mr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mf = '0;
        mr = '0;
      end
      mdl_eval(2, 1'b0, fi, mf, ef, nf);
      mdl_eval(4, 1'b1, ri, mr, er, nr);
      chk("fix.m_ready", 64'(f_ready), 64'(ef.m_ready));
      chk("fix.m_dvalid", 64'(f_dvalid), 64'(ef.m_dvalid));
      chk("fix.m_data", f_data, ef.m_data);
      chk("fix.s_valid", 64'(f_svalid), 64'(ef.s_valid));
      chk("fix.s_addr", f_saddr, ef.s_addr);
      chk("fix.s_size", 64'(f_ssize), 64'(ef.s_size));
      chk("fix.s_dready", 64'(f_sdready), 64'(ef.s_dready));
      chk("fix.gnt", 64'(f_gnt), 64'(ef.gnt));
      chk("fix.busy", 64'(f_busy), 64'(ef.busy));
      chk("rr.m_ready", 64'(r_ready), 64'(er.m_ready));
      chk("rr.m_dvalid", 64'(r_dvalid), 64'(er.m_dvalid));
      chk("rr.m_data", r_data, er.m_data);
      chk("rr.s_valid", 64'(r_svalid), 64'(er.s_valid));
      chk("rr.s_addr", r_saddr, er.s_addr);
      chk("rr.s_size", 64'(r_ssize), 64'(er.s_size));
      chk("rr.s_dready", 64'(r_sdready), 64'(er.s_dready));
      chk("rr.gnt", 64'(r_gnt), 64'(er.gnt));
      chk("rr.busy", 64'(r_busy), 64'(er.busy));
      @(posedge clk);
      if (!rst) begin
        mf = nf;
        mr = nr;
      end
    end
  end

  // Data beats actually consumed on the fixed-priority instance.
  always @(posedge clk) begin
    if (!rst && fi.s_dvalid && f_sdready) beats++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    int seq[5] = '{0, 1, 2, 3, 0};
    int b0;
    fi = '0;
    ri = '0;
    ri.addr = {64'h4000_0300, 64'h4000_0200, 64'h4000_0100, 64'h4000_0000};
    ri.size = {8'd8, 8'd4, 8'd2, 8'd1};
    tick(3);
    rst = 1'b0;
    #1;
    chk("reset.s_valid", 64'(f_svalid), 64'd0);
    chk("reset.busy", 64'(f_busy), 64'd0);
    chk("reset.gnt", 64'(r_gnt), 64'd0);

    // Single request from master 1 of the 2-master instance.
    fi.valid   = 4'b0010;
    fi.addr[1] = 64'h8000_0000;
    fi.size[1] = 8'd8;
    tick();
    chk("single.s_valid", 64'(f_svalid), 64'd1);
    chk("single.s_addr", f_saddr, 64'h8000_0000);
    chk("single.gnt", 64'(f_gnt), 64'd1);
    fi.s_ready = 1'b1;
    tick();
    fi.valid    = 4'b0000;
    fi.s_ready  = 1'b0;
    fi.s_dvalid = 1'b1;
    fi.s_data   = 64'hDEAD_BEEF;
    fi.dready   = 4'b0010;
    #1;
    chk("single.m_dvalid", 64'(f_dvalid), 64'b10);
    chk("single.m_data", f_data, 64'hDEAD_BEEF);
    tick();
    fi.s_dvalid = 1'b0;
    fi.dready   = 4'b0000;

    // Fixed priority: both request together, master 0 first, then one bubble.
    tick();
    fi.addr[0]  = 64'h1000_0000;
    fi.valid    = 4'b0011;
    fi.s_ready  = 1'b1;
    fi.s_dvalid = 1'b1;
    fi.dready   = 4'b0011;
    fi.s_data   = 64'h55;
    tick();
    chk("fixed.first_gnt", 64'(f_gnt), 64'd0);
    chk("fixed.first_valid", 64'(f_svalid), 64'd1);
    tick();
    chk("fixed.first_data", 64'(f_dvalid), 64'b01);
    fi.valid = 4'b0010;
    tick();
    chk("fixed.bubble_busy", 64'(f_busy), 64'd0);
    tick();
    chk("fixed.second_gnt", 64'(f_gnt), 64'd1);
    chk("fixed.second_valid", 64'(f_svalid), 64'd1);
    tick();
    fi.valid = 4'b0000;
    tick();
    fi = '0;

    // Back-pressure on both phases for master 0.
    fi.addr[0] = 64'h1000_0040;
    fi.size[0] = 8'd4;
    fi.valid   = 4'b0001;
    b0 = beats;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp.addr_hold", f_saddr, 64'h1000_0040);
      chk("bp.size_hold", 64'(f_ssize), 64'd4);
      chk("bp.no_ready", 64'(f_ready), 64'b00);
      tick();
    end
    fi.s_ready = 1'b1;
    #1;
    chk("bp.ready", 64'(f_ready), 64'b01);
    tick();
    fi.s_ready  = 1'b0;
    fi.valid    = 4'b0000;
    fi.s_dvalid = 1'b1;
    fi.s_data   = 64'h1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.dvalid_hold", 64'(f_dvalid), 64'b01);
      chk("bp.busy_hold", 64'(f_busy), 64'd1);
      tick();
    end
    fi.dready = 4'b0001;
    tick();
    fi.s_dvalid = 1'b0;
    fi.dready   = 4'b0000;
    #1;
    chk("bp.done_idle", 64'(f_busy), 64'd0);
    chk("bp.one_beat", 64'(beats - b0), 64'd1);

    // Round-robin with all four masters requesting continuously.
    ri.valid    = 4'b1111;
    ri.s_ready  = 1'b1;
    ri.s_dvalid = 1'b1;
    ri.dready   = 4'b1111;
    ri.s_data   = 64'hCAFE;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c % 3 == 1) begin
        chk("rr.order_gnt", 64'(r_gnt), 64'(seq[c/3]));
        chk("rr.order_valid", 64'(r_svalid), 64'd1);
      end else if (c % 3 == 2) begin
        chk("rr.order_dvalid", 64'(r_dvalid), 64'(4'b0001 << seq[c/3]));
      end else begin
        chk("rr.bubble", 64'(r_busy), 64'd0);
      end
    end
    ri.valid = 4'b0000;

    // Abort: master 2 withdraws in the address phase; pointer stays at 1.
    tick();
    ri.s_ready  = 1'b0;
    ri.s_dvalid = 1'b0;
    ri.valid    = 4'b0100;
    tick();
    chk("abort.gnt", 64'(r_gnt), 64'd2);
    ri.valid = 4'b0000;
    tick();
    chk("abort.idle", 64'(r_busy), 64'd0);
    ri.valid = 4'b1111;
    tick();
    chk("abort.ptr_kept", 64'(r_gnt), 64'd1);
    ri.s_ready = 1'b1;
    tick();
    chk("rst.in_data", 64'(r_sdready), 64'd1);
    ri.s_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst.s_dready", 64'(r_sdready), 64'd0);
    chk("rst.busy", 64'(r_busy), 64'd0);
    chk("rst.gnt", 64'(r_gnt), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst.regrant", 64'(r_gnt), 64'd0);
    chk("rst.regrant_valid", 64'(r_svalid), 64'd1);
    ri.valid = 4'b0000;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
